prog_clock_divider: RTL and testbench

- Programmable integer clock divider that sits downstream of the system clock and feeds the peripheral timing logic.
- Produces a one-cycle clock-enable strobe (tick) every N input cycles, plus a near-50% duty divided waveform (clk_out).
- The divisor can be changed at run time. The new value takes effect only at a period boundary, so clk_out never has a runt pulse.
- Fully synchronous to clk; no generated clocks are used inside the block.

---
 rtl/clkdiv_pkg.sv | 16 +
 rtl/div_counter.sv | 59 +++++
 rtl/prog_clock_divider.sv | 73 +++++++
 tb/tb_prog_clock_divider.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/clkdiv_pkg.sv
// Shared constants and helpers for the programmable clock divider.
package clkdiv_pkg;

   localparam int CNT_W_DEFAULT = 16;
   localparam int CNT_W_MAX     = 32;
   localparam int EXT_W         = CNT_W_MAX + 1;
   localparam int DIV_MIN       = 1;

   // Length of the high phase for divisor n: ceil(n/2).
   function automatic logic [EXT_W-1:0] hi_len(input logic [CNT_W_MAX-1:0] n);
      logic [EXT_W-1:0] n_ext;
      n_ext = {1'b0, n};
      return (n_ext + EXT_W'(1)) >> 1;
   endfunction

endpackage

// File: rtl/div_counter.sv
// Period counter: wrap detect, registered tick strobe and divided waveform.
module div_counter
   import clkdiv_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en_i,
   input  logic             apply_i,
   input  logic [CNT_W-1:0] div_q_i,
   input  logic [CNT_W-1:0] div_d_i,
   output logic             wrap_o,
   output logic             tick_o,
   output logic             clk_out_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             tick_q, tick_d;
   logic             clk_out_q, clk_out_d;
   logic [EXT_W-1:0] hi_len_d;

   assign wrap_o = en_i && (cnt_q == div_q_i - CNT_W'(1));

   // clk_out is judged against the divisor that is active after this edge,
   // so a divisor swap at the wrap starts the new waveform cleanly.
   always_comb begin
      cnt_d     = cnt_q;
      tick_d    = 1'b0;
      clk_out_d = clk_out_q;
      hi_len_d  = hi_len(CNT_W_MAX'(div_d_i));
      if (en_i) begin
         cnt_d  = wrap_o ? '0 : cnt_q + CNT_W'(1);
         tick_d = wrap_o;
      end else if (apply_i) begin
         cnt_d = '0;
      end
      if (en_i || apply_i)
         clk_out_d = (EXT_W'(cnt_d) < hi_len_d);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q     <= '0;
         tick_q    <= 1'b0;
         clk_out_q <= 1'b1;
      end else begin
         cnt_q     <= cnt_d;
         tick_q    <= tick_d;
         clk_out_q <= clk_out_d;
      end
   end

   assign tick_o    = tick_q;
   assign clk_out_o = clk_out_q;

   cnt_in_range: assert property (@(posedge clk) disable iff (rst) cnt_q < div_q_i);

endmodule

// File: rtl/prog_clock_divider.sv
// Programmable integer clock divider with glitch-free run-time divisor change.
module prog_clock_divider
   import clkdiv_pkg::*;
#(
   parameter int CNT_W       = CNT_W_DEFAULT,
   parameter int DEFAULT_DIV = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [CNT_W-1:0] div_val,
   input  logic             div_load,
   output logic             div_ack,
   output logic             tick,
   output logic             clk_out,
   output logic [CNT_W-1:0] cur_div
);

   localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);

   logic [CNT_W-1:0] div_q, div_d;
   logic [CNT_W-1:0] pend_val_q, pend_val_d;
   logic             pend_vld_q, pend_vld_d;
   logic             div_ack_q, div_ack_d;
   logic [CNT_W-1:0] req_val;
   logic             wrap;
   logic             apply;

   assign req_val = (div_val == '0) ? CNT_W'(DIV_MIN) : div_val;

   // While running, a pending divisor waits for the period boundary; when
   // frozen there is no waveform to protect, so it is taken immediately.
   assign apply = pend_vld_q && (!en || wrap);

   always_comb begin
      div_d      = apply ? pend_val_q : div_q;
      div_ack_d  = apply;
      pend_vld_d = div_load || (pend_vld_q && !apply);
      pend_val_d = div_load ? req_val : pend_val_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         div_q      <= DEF_DIV;
         pend_val_q <= DEF_DIV;
         pend_vld_q <= 1'b0;
         div_ack_q  <= 1'b0;
      end else begin
         div_q      <= div_d;
         pend_val_q <= pend_val_d;
         pend_vld_q <= pend_vld_d;
         div_ack_q  <= div_ack_d;
      end
   end

   div_counter #(
      .CNT_W (CNT_W)
   ) u_cnt (
      .clk       (clk),
      .rst       (rst),
      .en_i      (en),
      .apply_i   (apply),
      .div_q_i   (div_q),
      .div_d_i   (div_d),
      .wrap_o    (wrap),
      .tick_o    (tick),
      .clk_out_o (clk_out)
   );

   assign div_ack = div_ack_q;
   assign cur_div = div_q;

endmodule

// File: tb/tb_prog_clock_divider.sv
// Self-checking bench: directed vector table, corner sequences, random vs model.
module tb_prog_clock_divider;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b0;
   logic [15:0] div_val = '0;
   logic        div_load = 1'b0;
   logic        div_ack, tick, clk_out;
   logic [15:0] cur_div;

   int checks = 0;
   int errors = 0;

   prog_clock_divider #(.CNT_W(16), .DEFAULT_DIV(8)) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .div_val  (div_val),
      .div_load (div_load),
      .div_ack  (div_ack),
      .tick     (tick),
      .clk_out  (clk_out),
      .cur_div  (cur_div)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        r, e, l;
      logic [15:0] v;
      logic        t, c, a;
      logic [15:0] cur;
   } vec_t;

   vec_t vecs[$];

   // Reference model: position within the period, active and pending divisors.
   int m_pos, m_div, m_pend;
   bit m_pv, m_tick, m_clk, m_ack;

   task automatic model_edge(input logic r, e, l, input logic [15:0] v);
      bit bnd, app;
      int nd;
      if (r) begin
         m_pos = 0; m_div = 8; m_pv = 0;
         m_tick = 0; m_ack = 0; m_clk = 1;
      end else begin
         bnd = e && (m_pos == m_div - 1);
         app = m_pv && (!e || bnd);
         nd  = app ? m_pend : m_div;
         if (e) begin
            m_pos  = bnd ? 0 : m_pos + 1;
            m_tick = bnd;
            m_clk  = (m_pos < nd - nd / 2);
         end else begin
            m_tick = 0;
            if (app) begin m_pos = 0; m_clk = 1; end
         end
         m_ack = app;
         m_div = nd;
         if (l) begin
            m_pend = (v == 0) ? 1 : int'(v);
            m_pv   = 1;
         end else if (app) begin
            m_pv = 0;
         end
      end
   endtask

   function automatic logic [18:0] dut_vec();
      return {tick, clk_out, div_ack, cur_div};
   endfunction

   task automatic check(input string name, input logic [18:0] act, input logic [18:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got tick/clk/ack/div=%0b/%0b/%0b/%0d, expected %0b/%0b/%0b/%0d",
                  name, act[18], act[17], act[16], act[15:0], exp[18], exp[17], exp[16], exp[15:0]);
      end
   endtask

   task automatic step(input logic r, e, l, input logic [15:0] v);
      rst = r; en = e; div_load = l; div_val = v;
      @(posedge clk);
      model_edge(r, e, l, v);
      @(negedge clk);
      check("model", dut_vec(), {m_tick, m_clk, m_ack, 16'(m_div)});
   endtask

   task automatic stepx(input string name, input logic r, e, l, input logic [15:0] v,
                        input logic t, c, a, input logic [15:0] cur);
      step(r, e, l, v);
      check(name, dut_vec(), {t, c, a, cur});
   endtask

   function automatic void add(input logic r, e, l, input logic [15:0] v,
                               input logic t, c, a, input logic [15:0] cur);
      vec_t x;
      x.r = r; x.e = e; x.l = l; x.v = v; x.t = t; x.c = c; x.a = a; x.cur = cur;
      vecs.push_back(x);
   endfunction

   initial begin
      logic r, e, l;
      logic [15:0] v;

      // Reset, then N=8 free-running: tick on 8,16,24; clk_out 1111 0000.
      add(1, 0, 0, 0, 0, 1, 0, 8);
      for (int k = 1; k <= 24; k++) add(0, 1, 0, 0, (k % 8) == 0, (k % 8) < 4, 0, 8);
      // Load 5: old period finishes, then 111 00 with a single ack.
      add(0, 1, 1, 5, 0, 1, 0, 8);
      for (int k = 2; k <= 7; k++) add(0, 1, 0, 0, 0, k < 4, 0, 8);
      add(0, 1, 0, 0, 1, 1, 1, 5);
      for (int j = 1; j <= 10; j++) add(0, 1, 0, 0, (j % 5) == 0, (j % 5) < 3, 0, 5);
      // Load 0 is treated as 1: tick every cycle, clk_out stuck high.
      add(0, 1, 1, 0, 0, 1, 0, 5);
      for (int k = 2; k <= 4; k++) add(0, 1, 0, 0, 0, k < 3, 0, 5);
      add(0, 1, 0, 0, 1, 1, 1, 1);
      for (int j = 1; j <= 4; j++) add(0, 1, 0, 0, 1, 1, 0, 1);

      foreach (vecs[i])
         stepx($sformatf("vec%0d", i), vecs[i].r, vecs[i].e, vecs[i].l, vecs[i].v,
               vecs[i].t, vecs[i].c, vecs[i].a, vecs[i].cur);

      // Load while frozen applies on the next edge; then N=4, load 6 at cnt=1.
      stepx("idle_load4",  0, 0, 1, 4, 0, 1, 0, 1);
      stepx("idle_apply4", 0, 0, 0, 0, 0, 1, 1, 4);
      stepx("n4_cnt1",     0, 1, 0, 0, 0, 1, 0, 4);
      stepx("n4_load6",    0, 1, 1, 6, 0, 0, 0, 4);
      stepx("n4_cnt3",     0, 1, 0, 0, 0, 0, 0, 4);
      stepx("n4_wrap_ack", 0, 1, 0, 0, 1, 1, 1, 6);
      for (int j = 1; j <= 6; j++)
         stepx($sformatf("n6_%0d", j), 0, 1, 0, 0, j == 6, (j % 6) < 3, 0, 6);

      // Back to N=8, freeze for 10 cycles at cnt=3, wrap 5 cycles after resume.
      stepx("load8", 0, 1, 1, 8, 0, 1, 0, 6);
      for (int k = 2; k <= 5; k++) stepx("n6_tail", 0, 1, 0, 0, 0, k < 3, 0, 6);
      stepx("n8_ack", 0, 1, 0, 0, 1, 1, 1, 8);
      for (int k = 1; k <= 3; k++) stepx("n8_run", 0, 1, 0, 0, 0, 1, 0, 8);
      for (int k = 0; k < 10; k++) stepx("frozen", 0, 0, 0, 0, 0, 1, 0, 8);
      for (int k = 4; k <= 7; k++) stepx("resume", 0, 1, 0, 0, 0, 0, 0, 8);
      stepx("resume_wrap", 0, 1, 0, 0, 1, 1, 0, 8);

      // Reset mid-period with a pending load: pending value is discarded.
      stepx("pre_rst1", 0, 1, 0, 0, 0, 1, 0, 8);
      stepx("pre_rst2", 0, 1, 0, 0, 0, 1, 0, 8);
      stepx("pend3",    0, 1, 1, 3, 0, 1, 0, 8);
      stepx("pend_mid", 0, 1, 0, 0, 0, 0, 0, 8);
      stepx("mid_rst",  1, 1, 0, 0, 0, 1, 0, 8);
      for (int k = 1; k <= 8; k++)
         stepx($sformatf("post_rst%0d", k), 0, 1, 0, 0, k == 8, (k % 8) < 4, 0, 8);

      // Random traffic against the reference model.
      for (int i = 0; i < 3000; i++) begin
         r = ($urandom_range(0, 199) == 0);
         e = ($urandom_range(0, 3) != 0);
         l = ($urandom_range(0, 5) == 0);
         v = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(0, 40))
                                         : 16'($urandom_range(0, 12));
         step(r, e, l, v);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
